// File: rtl/mult64x64_seq.sv
// mult64x64_seq: builds a 128-bit unsigned product from four 32x32 partial
// products. It issues the partial products to an external pipelined
// mult32x32 and accumulates the 64-bit results with the correct shifts.
// One slot down-counter schedules both the issue slots and the capture slots.
// Capture never depends on what the multiplier pipeline happens to hold.

module mult64x64_seq #(
  parameter int MUL_LAT = 3  // mult32x32 pipeline depth, legal 1..8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic         busy,
  output logic         done,
  output logic [127:0] o,
  output logic         mul_ce,
  output logic [31:0]  mul_a,
  output logic [31:0]  mul_b,
  input  logic [63:0]  mul_o
);

  // Slot counter width covers the largest loaded value (MUL_LAT+3).
  localparam int CW = $clog2(MUL_LAT + 5);

  // Counter value loaded on the accepting edge E0. Before edge E(j) the
  // counter holds MUL_LAT+4-j, so completion happens when it reads zero.
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MUL_LAT + 3);
  // Counter value at the edge that issues the last partial product (k=3).
  localparam logic [CW-1:0] ISSUE_LAST = CW'(MUL_LAT + 1);
  // Reference value used to recover the issue index from the counter.
  localparam logic [CW-1:0] ISSUE_BASE = CW'(MUL_LAT + 4);
  // Capture slots are the last four counter values (3,2,1,0 -> k=0..3).
  localparam logic [CW-1:0] CAP_FIRST  = CW'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Architectural state.
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [63:0]     a_q,     a_d;
  logic [63:0]     b_q,     b_d;
  logic [127:0]    acc_q,   acc_d;
  logic [127:0]    o_q,     o_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            mul_ce_q, mul_ce_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;

  // Datapath helpers.
  logic            accept;
  logic            active;
  logic            capture;
  logic            issue_slot;
  logic [1:0]      issue_k;
  logic [1:0]      capture_k;
  logic [127:0]    partial;
  logic [127:0]    sum;

  // Slot decode: which partial product is issued or captured this edge.
  always_comb begin
    accept     = start && !busy_q;
    active     = (state_q == ISSUE) || (state_q == DRAIN);
    issue_slot = (state_q == ISSUE) && (cnt_q >= ISSUE_LAST);
    issue_k    = 2'(ISSUE_BASE - cnt_q);
    capture    = active && (cnt_q <= CAP_FIRST);
    capture_k  = ~cnt_q[1:0];
  end

  // Align the zero-extended partial product and add it to the accumulator.
  always_comb begin
    partial = '0;
    unique case (capture_k)
      2'd0:    partial = {64'd0, mul_o};
      2'd1,
      2'd2:    partial = {32'd0, mul_o, 32'd0};
      default: partial = {mul_o, 64'd0};
    endcase
    sum = acc_q + partial;
  end

  // Next-state and next-output logic for the sequencer.
  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    o_d      = o_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mul_ce_d = mul_ce_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          // Latch the operands and issue partial product k=0 on this
          // same edge, straight from the input ports.
          a_d      = a;
          b_d      = b;
          acc_d    = '0;
          cnt_d    = CNT_LOAD;
          mul_a_d  = a[31:0];
          mul_b_d  = b[31:0];
          busy_d   = 1'b1;
          mul_ce_d = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE, DRAIN: begin
        // Issue k=1..3 from the latched operands. Issue and capture slots
        // may overlap when the multiplier latency is short.
        if (issue_slot) begin
          mul_a_d = issue_k[1] ? a_q[63:32] : a_q[31:0];
          mul_b_d = issue_k[0] ? b_q[63:32] : b_q[31:0];
          if (cnt_q == ISSUE_LAST) begin
            state_d = DRAIN;
          end
        end

        if (capture) begin
          acc_d = sum;
        end

        if (cnt_q == '0) begin
          // The last capture slot also publishes the finished product.
          o_d      = sum;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          mul_ce_d = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      o_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mul_ce_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      o_q      <= o_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mul_ce_q <= mul_ce_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  // Drive the ports directly from flops.
  assign busy   = busy_q;
  assign done   = done_q;
  assign o      = o_q;
  assign mul_ce = mul_ce_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_mult64x64_seq.sv
// Testbench for mult64x64_seq: three instances (MUL_LAT = 1, 3, 8), each with
// its own behavioural mult32x32 pipeline. Expected products are queued when a
// start is driven and popped when the matching instance pulses done.

module tb_mult64x64_seq;

  localparam int DIDX   = 1;  // instance used for directed tests
  localparam int DLAT   = 3;  // its multiplier latency
  localparam int N_RAND = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start_v;
  logic [63:0]  a;
  logic [63:0]  b;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [2:0]   mul_ce_v;
  logic [127:0] o_v     [3];
  logic [31:0]  mul_a_v [3];
  logic [31:0]  mul_b_v [3];
  logic [63:0]  mul_o_v [3];

  logic [127:0] exp_q [3][$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] x,
                                           input logic [63:0] y);
    return {64'd0, x} * {64'd0, y};
  endfunction

  generate
    for (genvar i = 0; i < 3; i++) begin : g_dut
      localparam int LAT = (i == 0) ? 1 : ((i == 1) ? 3 : 8);

      logic [63:0]  pipe [LAT];
      logic [127:0] exp_v;

      mult64x64_seq #(.MUL_LAT(LAT)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start_v[i]),
        .a      (a),
        .b      (b),
        .busy   (busy_v[i]),
        .done   (done_v[i]),
        .o      (o_v[i]),
        .mul_ce (mul_ce_v[i]),
        .mul_a  (mul_a_v[i]),
        .mul_b  (mul_b_v[i]),
        .mul_o  (mul_o_v[i])
      );

      // Behavioural mult32x32: LAT register stages, advancing on mul_ce.
      always @(posedge clk) begin
        if (mul_ce_v[i]) begin
          pipe[0] <= {32'd0, mul_a_v[i]} * {32'd0, mul_b_v[i]};
          for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end
      end
      assign mul_o_v[i] = pipe[LAT-1];

      // Scoreboard: every done pulse must match the oldest queued product.
      always @(negedge clk) begin
        if (!rst && done_v[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("lat%0d_spurious_done", LAT), 128'd1, 128'd0);
          end else begin
            exp_v = exp_q[i].pop_front();
            check($sformatf("lat%0d_result", LAT), o_v[i], exp_v);
          end
        end
      end
    end
  endgenerate

  // Drive one start pulse on instance idx from a negedge; returns at the
  // negedge after the accepting edge.
  task automatic pulse_start(input int idx, input logic [63:0] av,
                             input logic [63:0] bv, input bit accepted);
    a = av;
    b = bv;
    start_v[idx] = 1'b1;
    if (accepted) exp_q[idx].push_back(ref_mul(av, bv));
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  // Called just after the accepting edge: busy must hold for DLAT+4 cycles
  // with done low, then done pulses with busy low.
  task automatic check_latency(input string tag);
    for (int n = 0; n < DLAT + 4; n++) begin
      check({tag, "_busy"}, {busy_v[DIDX], done_v[DIDX]}, 2'b10);
      @(negedge clk);
    end
    check({tag, "_done"}, {busy_v[DIDX], done_v[DIDX]}, 2'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst     = 1'b1;
    start_v = '0;
    a       = '0;
    b       = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_busy",   busy_v[DIDX],   0);
    check("rst_done",   done_v[DIDX],   0);
    check("rst_mul_ce", mul_ce_v[DIDX], 0);
    check("rst_o",      o_v[DIDX],      0);
    check("rst_mul_a",  mul_a_v[DIDX],  0);
    check("rst_mul_b",  mul_b_v[DIDX],  0);
    rst = 1'b0;
    @(negedge clk);

    // Basic, cross-half and maximum operands, issued back to back from DONE.
    pulse_start(DIDX, 64'd10, 64'd10, 1'b1);
    check_latency("basic");
    pulse_start(DIDX, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
    check_latency("cross_hi");
    pulse_start(DIDX, 64'd21, 64'h0000_0001_0019_F0A0, 1'b1);
    check_latency("cross_mix");
    pulse_start(DIDX, '1, '1, 1'b1);
    check_latency("max");
    check("max_value", o_v[DIDX], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    @(negedge clk);

    // Start while busy is ignored; start held in the DONE cycle is accepted.
    pulse_start(DIDX, 64'd3, 64'd5, 1'b1);
    @(negedge clk);
    pulse_start(DIDX, 64'd7, 64'd7, 1'b0);
    repeat (DLAT + 2) @(negedge clk);
    check("b2b_first_done", done_v[DIDX], 1);
    check("b2b_first_o", o_v[DIDX], 128'd15);
    pulse_start(DIDX, 64'd6, 64'd7, 1'b1);
    check("b2b_o_hold", o_v[DIDX], 128'd15);
    check_latency("b2b_second");
    @(negedge clk);

    // Reset in the middle of an operation discards it.
    pulse_start(DIDX, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy",   busy_v[DIDX],   0);
    check("midrst_done",   done_v[DIDX],   0);
    check("midrst_o",      o_v[DIDX],      0);
    check("midrst_mul_ce", mul_ce_v[DIDX], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(DIDX, 64'd2, 64'd9, 1'b1);
    check_latency("after_rst");
    @(negedge clk);

    // Random operands on all three latencies, started together.
    for (int n = 0; n < N_RAND; n++) begin
      int w;
      case (n)
        0:       begin a = '0; b = '1; end
        1:       begin a = '1; b = 64'd1; end
        2:       begin a = 64'hFFFF_FFFF_0000_0000; b = 64'h0000_0000_FFFF_FFFF; end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      endcase
      for (int i = 0; i < 3; i++) exp_q[i].push_back(ref_mul(a, b));
      start_v = 3'b111;
      @(negedge clk);
      start_v = 3'b000;
      w = 0;
      while (busy_v != 3'b000 && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (busy_v != 3'b000) begin
        check("rand_timeout", busy_v, 0);
        break;
      end
    end
    @(negedge clk);

    for (int i = 0; i < 3; i++) check("queue_empty", exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
